reg_write_arbiter: RTL and testbench

Arbitrates the single write port of the 16x8 two-read/one-write register file between two write-back requesters, e.g. the ALU and the load path. It uses round-robin fairness and a valid/ready handshake. Grants are registered, so the file's `we`/`wa`/`wd` are driven from flops. An optional post-reset clear sequencer zeroes all 16 registers before any requester is served.

---
 rtl/reg_write_arbiter_if.sv | 32 +++
 rtl/reg_write_arbiter.sv | 124 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// Write-back bus between the two requesters, the arbiter and the register file write port.
interface reg_write_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          busy;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output we, wa, wd, busy
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  we, wa, wd, busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with registered we/wa/wd.
// Optional post-reset clear of all registers: define REGARB_CLEAR_ON_RESET_EN.
module reg_write_arbiter #(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input logic            clk,
    input logic            rst,
    reg_write_arbiter_if.slave bus
);
    if (DEPTH != (1 << AW)) begin : g_depth_check
        $error("reg_write_arbiter: DEPTH must equal 2**AW");
    end

    logic          run_en;
    logic [1:0]    valid_w;
    logic [1:0]    gnt_w;
    logic          xfer;
    logic          last_q;
    logic          last_d;
    logic          we_q;
    logic          we_d;
    logic [AW-1:0] wa_q;
    logic [AW-1:0] wa_d;
    logic [DW-1:0] wd_q;
    logic [DW-1:0] wd_d;

    assign valid_w = {bus.req1_valid, bus.req0_valid};

    // last_q=1 means req1 won most recently, so req0 has priority on contention.
    always_comb begin
        gnt_w = 2'b00;
        if (run_en && !rst) begin
            if (valid_w[0] && (!valid_w[1] || last_q)) begin
                gnt_w[0] = 1'b1;
            end else if (valid_w[1]) begin
                gnt_w[1] = 1'b1;
            end
        end
    end

    assign xfer           = |gnt_w;
    assign bus.req0_ready = gnt_w[0];
    assign bus.req1_ready = gnt_w[1];

    always_comb begin
        we_d   = xfer;
        wa_d   = wa_q;
        wd_d   = wd_q;
        last_d = last_q;
        if (xfer) begin
            wa_d   = gnt_w[1] ? bus.req1_addr : bus.req0_addr;
            wd_d   = gnt_w[1] ? bus.req1_data : bus.req0_data;
            last_d = gnt_w[1];
        end
    end

`ifdef REGARB_CLEAR_ON_RESET_EN
    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state_q;
    logic [AW-1:0] clr_idx_q;

    // The final clear write and the switch to RUN share one edge, so busy drops with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            we_q      <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
            last_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    we_q      <= 1'b1;
                    wa_q      <= clr_idx_q;
                    wd_q      <= '0;
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == LAST_IDX) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    we_q   <= we_d;
                    wa_q   <= wa_d;
                    wd_q   <= wd_d;
                    last_q <= last_d;
                end
            endcase
        end
    end

    assign run_en   = (state_q == ST_RUN);
    assign bus.busy = (state_q == ST_CLEAR);
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            last_q <= 1'b1;
        end else begin
            we_q   <= we_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            last_q <= last_d;
        end
    end

    assign run_en   = 1'b1;
    assign bus.busy = 1'b0;
`endif

    assign bus.we = we_q;
    assign bus.wa = wa_q;
    assign bus.wd = wd_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a small register-file model on the write port.
module tb_reg_write_arbiter;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [DW-1:0] rf [DEPTH];

    always #5 clk = ~clk;

    reg_write_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    reg_write_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (bus.we) rf[bus.wa] <= bus.wd;
    end

    always @(negedge clk) begin
        if (!rst && bus.req0_valid && bus.req0_ready)
            $display("xfer req0 addr=%0d data=0x%02h", bus.req0_addr, bus.req0_data);
        if (!rst && bus.req1_valid && bus.req1_ready)
            $display("xfer req1 addr=%0d data=0x%02h", bus.req1_addr, bus.req1_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef REGARB_CLEAR_ON_RESET_EN
        repeat (DEPTH) step();
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 4'd9;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 4'd10;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            $display("FAIL reset_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready});
            failures++;
        end
        step();
        checks++;
        if ({bus.we, bus.wa, bus.wd} !== {1'b0, 4'd0, 8'd0}) begin
            $display("FAIL reset_outputs: we=%b wa=%0d wd=0x%02h expected 0/0/0x00", bus.we, bus.wa, bus.wd);
            failures++;
        end
`ifdef REGARB_CLEAR_ON_RESET_EN
        checks++;
        if (bus.busy !== 1'b1) begin
            $display("FAIL reset_busy: got %b expected 1", bus.busy);
            failures++;
        end
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] exp_a;
            exp_a = AW'(i);
            step();
            checks++;
            if ({bus.we, bus.wa, bus.wd, bus.busy} !== {1'b1, exp_a, 8'd0, (i < DEPTH - 1)}) begin
                $display("FAIL clear_write[%0d]: we=%b wa=%0d wd=0x%02h busy=%b expected 1/%0d/0x00/%b",
                         i, bus.we, bus.wa, bus.wd, bus.busy, exp_a, (i < DEPTH - 1));
                failures++;
            end
        end
        step();
        checks++;
        if ({bus.we, bus.busy} !== 2'b00) begin
            $display("FAIL clear_done: we=%b busy=%b expected 0/0", bus.we, bus.busy);
            failures++;
        end
        for (int r = 0; r < DEPTH; r++) begin
            checks++;
            if (rf[r] !== 8'h00) begin
                $display("FAIL clear_rf[%0d]: got 0x%02h expected 0x00", r, rf[r]);
                failures++;
            end
        end
`else
        checks++;
        if (bus.busy !== 1'b0) begin
            $display("FAIL reset_busy: got %b expected 0", bus.busy);
            failures++;
        end
        rst = 1'b0;
        idle_inputs();
        step();
        checks++;
        if ({bus.we, bus.busy} !== 2'b00) begin
            $display("FAIL idle_after_reset: we=%b busy=%b expected 0/0", bus.we, bus.busy);
            failures++;
        end
`endif
    endtask

    task automatic test_single();
        reset_dut();
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 4'd3;
        bus.req0_data  = 8'hAA;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            $display("FAIL single_ready: got %b expected 10", {bus.req0_ready, bus.req1_ready});
            failures++;
        end
        step();
        bus.req0_valid = 1'b0;
        checks++;
        if ({bus.we, bus.wa, bus.wd} !== {1'b1, 4'd3, 8'hAA}) begin
            $display("FAIL single_write: we=%b wa=%0d wd=0x%02h expected 1/3/0xaa", bus.we, bus.wa, bus.wd);
            failures++;
        end
        step();
        checks++;
        if ({bus.we, bus.wa, bus.wd} !== {1'b0, 4'd3, 8'hAA}) begin
            $display("FAIL single_hold: we=%b wa=%0d wd=0x%02h expected 0/3/0xaa", bus.we, bus.wa, bus.wd);
            failures++;
        end
        checks++;
        if (rf[3] !== 8'hAA) begin
            $display("FAIL single_rf: r3=0x%02h expected 0xaa", rf[3]);
            failures++;
        end
    endtask

    task automatic test_alternate();
        reset_dut();
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 4'd1;
        bus.req0_data  = 8'h11;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 4'd2;
        bus.req1_data  = 8'h22;
        for (int i = 0; i < 4; i++) begin
            logic [1:0]    exp_rdy;
            logic [AW-1:0] exp_a;
            logic [DW-1:0] exp_d;
            exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
            exp_a   = (i % 2 == 0) ? 4'd1 : 4'd2;
            exp_d   = (i % 2 == 0) ? 8'h11 : 8'h22;
            #1;
            checks++;
            if ({bus.req0_ready, bus.req1_ready} !== exp_rdy) begin
                $display("FAIL alt_grant[%0d]: got %b expected %b", i, {bus.req0_ready, bus.req1_ready}, exp_rdy);
                failures++;
            end
            step();
            checks++;
            if ({bus.we, bus.wa, bus.wd} !== {1'b1, exp_a, exp_d}) begin
                $display("FAIL alt_write[%0d]: we=%b wa=%0d wd=0x%02h expected 1/%0d/0x%02h",
                         i, bus.we, bus.wa, bus.wd, exp_a, exp_d);
                failures++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_same_addr();
        reset_dut();
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 4'd5;
        bus.req0_data  = 8'h55;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 4'd5;
        bus.req1_data  = 8'h66;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            $display("FAIL same_first_grant: got %b expected 10", {bus.req0_ready, bus.req1_ready});
            failures++;
        end
        step();
        bus.req0_valid = 1'b0;
        checks++;
        if ({bus.wa, bus.wd} !== {4'd5, 8'h55}) begin
            $display("FAIL same_first_write: wa=%0d wd=0x%02h expected 5/0x55", bus.wa, bus.wd);
            failures++;
        end
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
            $display("FAIL same_second_grant: got %b expected 01", {bus.req0_ready, bus.req1_ready});
            failures++;
        end
        step();
        bus.req1_valid = 1'b0;
        checks++;
        if ({bus.we, bus.wa, bus.wd} !== {1'b1, 4'd5, 8'h66}) begin
            $display("FAIL same_second_write: we=%b wa=%0d wd=0x%02h expected 1/5/0x66", bus.we, bus.wa, bus.wd);
            failures++;
        end
        step();
        checks++;
        if (rf[5] !== 8'h66) begin
            $display("FAIL same_rf: r5=0x%02h expected 0x66", rf[5]);
            failures++;
        end
    endtask

    task automatic test_reset_mid_run();
        reset_dut();
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 4'd7;
        bus.req0_data  = 8'h70;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 4'd8;
        bus.req1_data  = 8'h80;
        step();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            $display("FAIL midrun_reset_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready});
            failures++;
        end
        step();
        checks++;
        if (bus.we !== 1'b0) begin
            $display("FAIL midrun_dropped: we=%b expected 0", bus.we);
            failures++;
        end
        rst = 1'b0;
`ifdef REGARB_CLEAR_ON_RESET_EN
        repeat (DEPTH) step();
`endif
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            $display("FAIL midrun_last_reset: got %b expected 10", {bus.req0_ready, bus.req1_ready});
            failures++;
        end
        idle_inputs();
        step();
    endtask

`ifdef REGARB_CLEAR_ON_RESET_EN
    task automatic test_reset_mid_clear();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 4'd12;
        bus.req1_data  = 8'h3C;
        repeat (7) step();
        checks++;
        if (bus.wa !== 4'd6) begin
            $display("FAIL midclear_progress: wa=%0d expected 6", bus.wa);
            failures++;
        end
        rst = 1'b1;
        step();
        checks++;
        if ({bus.we, bus.busy} !== 2'b01) begin
            $display("FAIL midclear_reset: we=%b busy=%b expected 0/1", bus.we, bus.busy);
            failures++;
        end
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] exp_a;
            exp_a = AW'(i);
            #1;
            checks++;
            if (bus.req1_ready !== 1'b0) begin
                $display("FAIL midclear_ready[%0d]: got %b expected 0", i, bus.req1_ready);
                failures++;
            end
            step();
            checks++;
            if ({bus.we, bus.wa, bus.wd} !== {1'b1, exp_a, 8'd0}) begin
                $display("FAIL restart_write[%0d]: we=%b wa=%0d wd=0x%02h expected 1/%0d/0x00",
                         i, bus.we, bus.wa, bus.wd, exp_a);
                failures++;
            end
        end
        #1;
        checks++;
        if ({bus.req1_ready, bus.busy} !== 2'b10) begin
            $display("FAIL first_grant_after_clear: ready1=%b busy=%b expected 1/0", bus.req1_ready, bus.busy);
            failures++;
        end
        step();
        bus.req1_valid = 1'b0;
        checks++;
        if ({bus.we, bus.wa, bus.wd} !== {1'b1, 4'd12, 8'h3C}) begin
            $display("FAIL post_clear_write: we=%b wa=%0d wd=0x%02h expected 1/12/0x3c", bus.we, bus.wa, bus.wd);
            failures++;
        end
        step();
    endtask
`else
    task automatic test_first_cycle();
        idle_inputs();
        rst = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 4'd14;
        bus.req1_data  = 8'h5A;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.req1_ready, bus.busy} !== 2'b10) begin
            $display("FAIL first_cycle_ready: ready1=%b busy=%b expected 1/0", bus.req1_ready, bus.busy);
            failures++;
        end
        step();
        bus.req1_valid = 1'b0;
        checks++;
        if ({bus.we, bus.wa, bus.wd} !== {1'b1, 4'd14, 8'h5A}) begin
            $display("FAIL first_cycle_write: we=%b wa=%0d wd=0x%02h expected 1/14/0x5a", bus.we, bus.wa, bus.wd);
            failures++;
        end
        step();
    endtask
`endif

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_single();
        test_alternate();
        test_same_addr();
        test_reset_mid_run();
`ifdef REGARB_CLEAR_ON_RESET_EN
        test_reset_mid_clear();
`else
        test_first_cycle();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
